// File: rtl/line_fetch_pkg.sv
// Shared video types for the line fetcher: fetch FSM states, the 24-bit
// pixel type and the framebuffer address helper.
package video_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // Byte address of the first pixel word of a line in a 4-byte-per-pixel framebuffer.
  function automatic logic [31:0] line_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] line,
                                                 input logic [31:0] width);
    return base + ((line * width) << 2);
  endfunction

endpackage

// File: rtl/line_fetch_if.sv
// Read-only memory bus between the line fetcher (master) and the framebuffer
// memory (slave). Requests are accepted by gnt; data returns in order on rvalid.
interface line_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/line_fetch_ram.sv
// One line of pixels: single write port, single registered read port,
// written so synthesis maps it onto block RAM. Contents are never reset.
module linebuf_ram
  import video_pkg::*;
#(
  parameter int DEPTH = 960,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pixel_t        wdata,
  input  logic [AW-1:0] raddr,
  output pixel_t        rdata
);

  pixel_t mem [0:DEPTH-1];

  // Write-first is irrelevant here: display and fetch never touch the same buffer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_fetch.sv
// Double-buffered scanline fetcher. While one line buffer feeds the HDMI
// core, the other is refilled from the framebuffer for the next row; the two
// are swapped near the end of the row, flagging underrun if the refill lagged.
module line_fetch
  import video_pkg::*;
#(
  parameter int          HWIDTH  = 960,
  parameter int          VHEIGHT = 600,
  parameter int          HMAX    = 1199,
  parameter int          VMAX    = 624,
  parameter logic [31:0] FB_BASE = 32'h0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [10:0]   xpixel,
  input  logic [10:0]   ypixel,
  output logic [7:0]    red,
  output logic [7:0]    grn,
  output logic [7:0]    blu,
  line_fetch_if.master  mem,
  output logic          underrun,
  input  logic          underrun_clr
);

  localparam int AW = (HWIDTH > 1) ? $clog2(HWIDTH) : 1;
  localparam int CW = $clog2(HWIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(HWIDTH - 1);

  fetch_state_t  state;
  logic          front_sel;
  logic          swap_armed;
  logic [CW-1:0] req_idx;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop_cnt;

  logic          vis_q;
  logic          sel_q;
  pixel_t        q0;
  pixel_t        q1;

  logic [31:0]   ynext;
  logic [31:0]   target_line;
  logic [31:0]   target_addr;
  logic          visible;
  logic          trigger;
  logic          at_swap;
  logic          gnt_fire;
  logic          rv_drop;
  logic          rv_write;
  logic [CW-1:0] outst_next;
  logic [CW-1:0] drop_after;
  logic [AW-1:0] raddr;
  logic          unused_rdata_hi;

  // The top byte of each framebuffer word is padding and never displayed.
  assign unused_rdata_hi = ^mem.mem_rdata[31:24];

  assign ynext       = 32'(ypixel) + 32'd1;
  assign visible     = (32'(xpixel) < 32'(HWIDTH)) && (32'(ypixel) < 32'(VHEIGHT));
  assign trigger     = (32'(xpixel) == 32'(HWIDTH)) &&
                       ((ynext < 32'(VHEIGHT)) || (32'(ypixel) == 32'(VMAX)));
  assign target_line = (ynext < 32'(VHEIGHT)) ? ynext : 32'd0;
  assign target_addr = line_byte_addr(FB_BASE, target_line, 32'(HWIDTH));
  assign at_swap     = (32'(xpixel) == 32'(HMAX)) && swap_armed;

  assign gnt_fire    = mem.mem_req && mem.mem_gnt;
  assign rv_drop     = mem.mem_rvalid && (drop_cnt != '0);
  assign rv_write    = mem.mem_rvalid && (drop_cnt == '0) && (state != ST_IDLE);
  assign outst_next  = outst + CW'(gnt_fire) - CW'(mem.mem_rvalid);
  assign drop_after  = drop_cnt - CW'(rv_drop);

  // Fetch FSM: issue HWIDTH reads, collect HWIDTH returns, swap/abort at row end.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= 32'h0;
      req_idx      <= '0;
      wr_idx       <= '0;
      outst        <= '0;
      drop_cnt     <= '0;
      front_sel    <= 1'b0;
      swap_armed   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      outst    <= outst_next;
      drop_cnt <= drop_after;
      if (rv_write) begin
        wr_idx <= wr_idx + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (trigger) begin
            state        <= ST_FETCH;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= target_addr;
            req_idx      <= '0;
            wr_idx       <= '0;
            swap_armed   <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (gnt_fire) begin
            mem.mem_addr <= mem.mem_addr + 32'd4;
            req_idx      <= req_idx + 1'b1;
            if (req_idx == LAST_IDX) begin
              mem.mem_req <= 1'b0;
              state       <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (rv_write && (wr_idx == LAST_IDX)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A late fetch is abandoned; whatever is still in flight gets discarded.
      if (at_swap) begin
        front_sel  <= ~front_sel;
        swap_armed <= 1'b0;
        if (state != ST_IDLE) begin
          state       <= ST_IDLE;
          mem.mem_req <= 1'b0;
          req_idx     <= '0;
          wr_idx      <= '0;
          drop_cnt    <= outst_next;
        end
      end

      if (at_swap && (state != ST_IDLE)) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

  // Remember visibility and which buffer was front for the pixel being read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vis_q <= 1'b0;
      sel_q <= 1'b0;
    end else begin
      vis_q <= visible;
      sel_q <= front_sel;
    end
  end

  assign raddr = visible ? xpixel[AW-1:0] : '0;

  linebuf_ram #(.DEPTH(HWIDTH), .AW(AW)) u_buf0 (
    .clk   (clk),
    .we    (rv_write && front_sel),
    .waddr (wr_idx[AW-1:0]),
    .wdata (mem.mem_rdata[23:0]),
    .raddr (raddr),
    .rdata (q0)
  );

  linebuf_ram #(.DEPTH(HWIDTH), .AW(AW)) u_buf1 (
    .clk   (clk),
    .we    (rv_write && !front_sel),
    .waddr (wr_idx[AW-1:0]),
    .wdata (mem.mem_rdata[23:0]),
    .raddr (raddr),
    .rdata (q1)
  );

  assign {red, grn, blu} = vis_q ? (sel_q ? q1 : q0) : 24'h0;

endmodule

// File: tb/tb_line_fetch.sv
// Directed bench for line_fetch: drives the raster position by hand and
// models a framebuffer whose word n holds n, with a one-cycle read latency.
module tb_line_fetch;

  localparam logic [31:0] FB_BASE = 32'h1000_0000;

  logic        clk;
  logic        rstn;
  logic [10:0] xpixel;
  logic [10:0] ypixel;
  logic [7:0]  red;
  logic [7:0]  grn;
  logic [7:0]  blu;
  logic        underrun;
  logic        underrun_clr;
  logic        gnt_en;
  logic [23:0] rgb;

  int checks_total;
  int checks_passed;

  line_fetch_if mem_bus ();

  line_fetch #(
    .HWIDTH  (960),
    .VHEIGHT (600),
    .HMAX    (1199),
    .VMAX    (624),
    .FB_BASE (FB_BASE)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .xpixel       (xpixel),
    .ypixel       (ypixel),
    .red          (red),
    .grn          (grn),
    .blu          (blu),
    .mem          (mem_bus.master),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  assign rgb             = {red, grn, blu};
  assign mem_bus.mem_gnt = gnt_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer model: word n = n, top byte filled with junk that must be ignored.
  always @(posedge clk) begin
    if (!rstn) begin
      mem_bus.mem_rvalid <= 1'b0;
      mem_bus.mem_rdata  <= 32'h0;
    end else begin
      mem_bus.mem_rvalid <= mem_bus.mem_req && mem_bus.mem_gnt;
      mem_bus.mem_rdata  <= {8'hA5, 24'((mem_bus.mem_addr - FB_BASE) >> 2)};
    end
  end

  task automatic applyStimulus(input int x, input int y);
    xpixel = 11'(x);
    ypixel = 11'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic waitFetchDone(input int x, input int y);
    for (int n = 0; n < 1100 && mem_bus.mem_req; n++) begin
      applyStimulus(x, y);
    end
    checkOutput("fetch_done", 32'(mem_bus.mem_req), 32'h0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(x, y);
    end
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rstn          = 1'b0;
    gnt_en        = 1'b1;
    underrun_clr  = 1'b0;
    xpixel        = '0;
    ypixel        = '0;

    $display("[TB] reset state");
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("rst_mem_req", 32'(mem_bus.mem_req), 32'h0);
    checkOutput("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    checkOutput("rst_rgb", 32'(rgb), 32'h0);
    checkOutput("rst_underrun", 32'(underrun), 32'h0);
    rstn = 1'b1;
    applyStimulus(0, 0);

    $display("[TB] fetch line 5 and display it");
    applyStimulus(960, 4);
    checkOutput("l5_req", 32'(mem_bus.mem_req), 32'h1);
    checkOutput("l5_addr", mem_bus.mem_addr, 32'h1000_4B00);
    waitFetchDone(1000, 4);
    applyStimulus(1199, 4);
    checkOutput("l5_no_underrun", 32'(underrun), 32'h0);
    applyStimulus(0, 5);
    checkOutput("l5_x0", 32'(rgb), 32'h0000_12C0);
    applyStimulus(1, 5);
    checkOutput("l5_x1", 32'(rgb), 32'h0000_12C1);
    applyStimulus(500, 5);
    checkOutput("l5_x500", 32'(rgb), 32'h0000_14B4);
    applyStimulus(959, 5);
    checkOutput("l5_x959", 32'(rgb), 32'h0000_167F);

    $display("[TB] blanking region");
    applyStimulus(1000, 5);
    checkOutput("blank_x1000", 32'(rgb), 32'h0);
    applyStimulus(959, 599);
    checkOutput("last_row_visible", 32'(rgb), 32'h0000_167F);
    applyStimulus(10, 600);
    checkOutput("blank_y600", 32'(rgb), 32'h0);
    applyStimulus(960, 600);
    checkOutput("blank_x960_y600", 32'(rgb), 32'h0);
    applyStimulus(961, 600);
    checkOutput("no_fetch_y600", 32'(mem_bus.mem_req), 32'h0);

    $display("[TB] wrap to line 0");
    applyStimulus(960, 624);
    checkOutput("l0_req", 32'(mem_bus.mem_req), 32'h1);
    checkOutput("l0_addr", mem_bus.mem_addr, FB_BASE);
    waitFetchDone(1000, 624);
    applyStimulus(1199, 624);
    applyStimulus(7, 0);
    checkOutput("l0_x7", 32'(rgb), 32'h0000_0007);
    applyStimulus(959, 0);
    checkOutput("l0_x959", 32'(rgb), 32'h0000_03BF);

    $display("[TB] grant withheld, underrun at row end");
    gnt_en = 1'b0;
    applyStimulus(960, 10);
    checkOutput("stall_addr", mem_bus.mem_addr, 32'h1000_A500);
    for (int x = 961; x <= 1198; x++) begin
      applyStimulus(x, 10);
    end
    checkOutput("stall_req_held", 32'(mem_bus.mem_req), 32'h1);
    checkOutput("stall_no_underrun_yet", 32'(underrun), 32'h0);
    applyStimulus(1199, 10);
    checkOutput("stall_underrun", 32'(underrun), 32'h1);
    checkOutput("stall_req_dropped", 32'(mem_bus.mem_req), 32'h0);
    for (int n = 0; n < 61; n++) begin
      applyStimulus(n, 11);
    end
    gnt_en = 1'b1;
    for (int n = 61; n < 81; n++) begin
      applyStimulus(n, 11);
    end
    checkOutput("stall_req_stays_low", 32'(mem_bus.mem_req), 32'h0);
    checkOutput("underrun_sticky", 32'(underrun), 32'h1);

    $display("[TB] clear underrun, then a clean fetch");
    underrun_clr = 1'b1;
    applyStimulus(100, 11);
    underrun_clr = 1'b0;
    checkOutput("underrun_cleared", 32'(underrun), 32'h0);
    applyStimulus(960, 11);
    checkOutput("l12_addr", mem_bus.mem_addr, 32'h1000_B400);
    waitFetchDone(1000, 11);
    applyStimulus(1199, 11);
    checkOutput("l12_no_underrun", 32'(underrun), 32'h0);
    applyStimulus(0, 12);
    checkOutput("l12_x0", 32'(rgb), 32'h0000_2D00);
    applyStimulus(100, 12);
    checkOutput("l12_x100", 32'(rgb), 32'h0000_2D64);

    $display("[TB] abort with grants in flight, next fetch restarts cleanly");
    applyStimulus(960, 20);
    for (int x = 961; x <= 1199; x++) begin
      applyStimulus(x, 20);
    end
    checkOutput("abort_underrun", 32'(underrun), 32'h1);
    checkOutput("abort_req_low", 32'(mem_bus.mem_req), 32'h0);
    underrun_clr = 1'b1;
    applyStimulus(0, 21);
    underrun_clr = 1'b0;
    applyStimulus(960, 21);
    checkOutput("l22_addr", mem_bus.mem_addr, 32'h1001_4A00);
    waitFetchDone(1000, 21);
    applyStimulus(1199, 21);
    checkOutput("l22_no_underrun", 32'(underrun), 32'h0);
    applyStimulus(0, 22);
    checkOutput("l22_x0", 32'(rgb), 32'h0000_5280);
    applyStimulus(3, 22);
    checkOutput("l22_x3", 32'(rgb), 32'h0000_5283);

    $display("[TB] reset in the middle of a fetch");
    applyStimulus(960, 30);
    checkOutput("l31_addr", mem_bus.mem_addr, 32'h1001_D100);
    for (int n = 0; n < 400; n++) begin
      applyStimulus(5, 30);
    end
    checkOutput("l31_i400_addr", mem_bus.mem_addr, 32'h1001_D740);
    checkOutput("pre_reset_rgb", 32'(rgb), 32'h0000_5285);
    rstn = 1'b0;
    applyStimulus(5, 30);
    checkOutput("midrst_req", 32'(mem_bus.mem_req), 32'h0);
    checkOutput("midrst_rgb", 32'(rgb), 32'h0);
    checkOutput("midrst_addr", mem_bus.mem_addr, 32'h0);
    rstn = 1'b1;
    applyStimulus(0, 40);
    applyStimulus(960, 40);
    checkOutput("l41_addr", mem_bus.mem_addr, 32'h1002_6700);
    waitFetchDone(1000, 40);
    applyStimulus(1199, 40);
    checkOutput("l41_no_underrun", 32'(underrun), 32'h0);
    applyStimulus(0, 41);
    checkOutput("l41_x0", 32'(rgb), 32'h0000_99C0);
    applyStimulus(959, 41);
    checkOutput("l41_x959", 32'(rgb), 32'h0000_9D7F);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
